// File: rtl/eth_capture_ring.sv
// eth_capture_ring: multi-channel packet capture into a memory ring with per-packet header words
module eth_capture_ring #(
  parameter int          NCH        = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h10000000,
  parameter int          RING_WORDS = 4096,
  parameter int          MAX_LEN    = 1536,
  parameter int          FIFO_DEPTH = 16,
  localparam int         PW         = $clog2(RING_WORDS),
  localparam int         FW         = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [8*NCH-1:0] i_rxdata,
  input  logic [NCH-1:0]   i_rxvalid,
  input  logic [NCH-1:0]   i_rxsop,
  input  logic [NCH-1:0]   i_rxeop,
  input  logic [PW-1:0]    i_rd_ptr,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_wr_valid,
  input  logic             i_wr_ready,
  output logic [PW-1:0]    o_wr_ptr,
  output logic [15:0]      o_drop_count,
  output logic             o_busy
);
  localparam int MAX_WORDS = (MAX_LEN + 3) / 4;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, HEADER} state_t;
  state_t state_q, state_d;
  logic [3:0] ch_q, ch_d, win, sel;
  logic [PW-1:0] hdr_q, hdr_d, k_q, k_d, ptr_q, ptr_d, used, push_idx;
  logic [PW:0] free;
  logic [15:0] len_q, len_d, drop_q, drop_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic trunc_q, trunc_d, ovf_q, ovf_d;
  logic [FW-1:0] rd_q, rd_d, wp_q, wp_d;
  logic [FW:0] cnt_q, cnt_d;
  logic [PW+31:0] mem_q [FIFO_DEPTH];
  logic [PW+31:0] head;
  logic [NCH-1:0] sops;
  logic [4:0] nsop;
  logic [16:0] drop_sum, wlen;
  logic [7:0] rx_byte;
  logic [31:0] push_data;
  logic push, pop, full, accept, lv, ls, le;
  assign head         = mem_q[rd_q];
  assign o_wr_valid   = cnt_q != '0;
  assign o_wr_addr    = o_wr_valid ? BASE_ADDR + 32'({head[PW+31:32], 2'b00}) : '0;
  assign o_wr_data    = o_wr_valid ? head[31:0] : '0;
  assign o_wr_ptr     = ptr_q;
  assign o_drop_count = drop_q;
  assign o_busy       = state_q != IDLE || cnt_q != '0;
  // Channel arbitration, packing, FIFO push/pop and next-state logic
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    hdr_d = hdr_q;
    k_d = k_q;
    ptr_d = ptr_q;
    len_d = len_q;
    acc_d = acc_q;
    bcnt_d = bcnt_q;
    trunc_d = trunc_q;
    ovf_d = ovf_q;
    push = 1'b0;
    push_idx = '0;
    push_data = '0;
    accept = 1'b0;
    sops = i_rxvalid & i_rxsop;
    win = '0;
    nsop = '0;
    for (int i = NCH - 1; i >= 0; i--) if (sops[i]) win = 4'(i);
    for (int i = 0; i < NCH; i++) nsop = nsop + 5'(sops[i]);
    sel = state_q == IDLE ? win : ch_q;
    rx_byte = 8'(i_rxdata >> {sel, 3'b000});
    lv = 1'(i_rxvalid >> sel);
    ls = 1'(i_rxsop >> sel);
    le = 1'(i_rxeop >> sel);
    used = ptr_q - i_rd_ptr;
    free = (PW+1)'(RING_WORDS) - {1'b0, used};
    full = cnt_q == (FW+1)'(FIFO_DEPTH);
    pop = o_wr_valid && i_wr_ready;
    wlen = (17'(len_q) + 17'd3) >> 2;
    unique case (state_q)
      IDLE: begin
        if (nsop != '0 && i_enable && free >= (PW+1)'(MAX_WORDS + 1)) begin
          accept = 1'b1;
          hdr_d = ptr_q;
          ch_d = win;
          acc_d = {16'd0, rx_byte};
          bcnt_d = 2'd1;
          len_d = 16'd1;
          k_d = '0;
          trunc_d = 1'b0;
          ovf_d = 1'b0;
          state_d = le ? FLUSH : CAPTURE;
        end
      end
      CAPTURE: begin
        if (lv && ls) begin
          trunc_d = 1'b1;
          state_d = FLUSH;
        end else if (lv) begin
          if (!ovf_q && len_q >= 16'(MAX_LEN)) trunc_d = 1'b1;
          else if (!ovf_q && bcnt_q == 2'd3 && full) begin
            ovf_d = 1'b1;
            len_d = len_q - 16'd3;
            bcnt_d = 2'd0;
          end else if (!ovf_q && bcnt_q == 2'd3) begin
            push = 1'b1;
            push_idx = hdr_q + PW'(1) + k_q;
            push_data = {rx_byte, acc_q};
            k_d = k_q + PW'(1);
            len_d = len_q + 16'd1;
            bcnt_d = 2'd0;
          end else if (!ovf_q) begin
            acc_d = (bcnt_q == 2'd0 ? 24'd0 : acc_q) | (24'(rx_byte) << {bcnt_q, 3'b000});
            bcnt_d = bcnt_q + 2'd1;
            len_d = len_q + 16'd1;
          end
          if (le) state_d = FLUSH;
        end
      end
      FLUSH: begin
        push = bcnt_q != 2'd0 && !ovf_q && !full;
        push_idx = hdr_q + PW'(1) + k_q;
        push_data = {8'd0, acc_q};
        bcnt_d = push ? 2'd0 : bcnt_q;
        state_d = (bcnt_q == 2'd0 || ovf_q || push) ? HEADER : FLUSH;
      end
      HEADER: begin
        push = !full;
        push_idx = hdr_q;
        push_data = {1'b1, trunc_q, ovf_q, 1'b0, ch_q, 8'h00, len_q};
        ptr_d = push ? hdr_q + PW'(1) + PW'(wlen) : ptr_q;
        state_d = push ? IDLE : HEADER;
      end
    endcase
    drop_sum = 17'(drop_q) + 17'(nsop - 5'(accept));
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    rd_d = rd_q + FW'(pop);
    wp_d = wp_q + FW'(push);
    cnt_d = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
  end
  // State and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= '0;
      hdr_q <= '0;
      k_q <= '0;
      ptr_q <= '0;
      len_q <= '0;
      drop_q <= '0;
      acc_q <= '0;
      bcnt_q <= '0;
      trunc_q <= 1'b0;
      ovf_q <= 1'b0;
      rd_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      hdr_q <= hdr_d;
      k_q <= k_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
      drop_q <= drop_d;
      acc_q <= acc_d;
      bcnt_q <= bcnt_d;
      trunc_q <= trunc_d;
      ovf_q <= ovf_d;
      rd_q <= rd_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  // Write FIFO storage: word index and data per entry
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {push_idx, push_data};
  end
endmodule
